// File: rtl/rx_byte_packer.sv
// Packs an 8-bit byte stream little-endian into 32-bit words with byte enables;
// a flush emits a zero-padded partial word. Optional counters: RX_PACKER_STATS_EN.
module rx_byte_packer #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                byte_valid_i,
  output logic                                byte_ready_o,
  input  logic [InDataWidth-1:0]              byte_i,
  input  logic                                flush_i,
  output logic                                word_valid_o,
  input  logic                                word_ready_i,
  output logic [OutDataWidth-1:0]             word_o,
  output logic [OutDataWidth/InDataWidth-1:0] word_be_o,
  output logic                                busy_o
`ifdef RX_PACKER_STATS_EN
  ,
  input  logic                                stats_clr_i,
  output logic [15:0]                         words_emitted_o,
  output logic [15:0]                         partial_words_o
`endif
);

  localparam int BytesPerWord = OutDataWidth / InDataWidth;
  localparam int CntW = $clog2(BytesPerWord + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BytesPerWord);

  logic [OutDataWidth-1:0] acc_q, acc_d, acc_n;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_n;
  logic                    flush_pend_q, flush_pend_d;
  logic                    word_valid_q, word_valid_d;
  logic [OutDataWidth-1:0] word_q, word_d;
  logic [BytesPerWord-1:0] be_q, be_d, be_n;
  logic                    accept, out_free, flush_eff, emit;

  assign byte_ready_o = (cnt_q < CntFull) && !flush_pend_q;
  assign accept       = byte_valid_i && byte_ready_o;
  assign out_free     = !word_valid_q || word_ready_i;
  // A pending flush behaves like a flush request that repeats until it can emit.
  assign flush_eff    = flush_pend_q || flush_i;

  always_comb begin
    acc_n = acc_q;
    cnt_n = cnt_q;
    be_n  = '0;
    for (int i = 0; i < BytesPerWord; i++) begin
      if (accept && (cnt_q == CntW'(i))) begin
        acc_n[i*InDataWidth +: InDataWidth] = byte_i;
      end
    end
    if (accept) begin
      cnt_n = cnt_q + 1'b1;
    end
    for (int i = 0; i < BytesPerWord; i++) begin
      be_n[i] = (cnt_n > CntW'(i));
    end
  end

  assign emit = out_free && ((cnt_n == CntFull) || (flush_eff && (cnt_n != '0)));

  always_comb begin
    acc_d        = acc_n;
    cnt_d        = cnt_n;
    flush_pend_d = flush_pend_q;
    word_valid_d = word_valid_q;
    word_d       = word_q;
    be_d         = be_q;
    if (word_valid_q && word_ready_i) begin
      word_valid_d = 1'b0;
    end
    if (emit) begin
      // Clearing acc on emission keeps lanes beyond the fill count at zero.
      word_valid_d = 1'b1;
      word_d       = acc_n;
      be_d         = be_n;
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else if (flush_eff && (cnt_n != '0)) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
      be_q         <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
      be_q         <= be_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign word_be_o    = be_q;
  assign busy_o       = (cnt_q != '0) || word_valid_q || flush_pend_q;

`ifdef RX_PACKER_STATS_EN
  logic [15:0] words_q, words_d, partial_q, partial_d;
  logic        handshake;

  assign handshake = word_valid_q && word_ready_i;

  always_comb begin
    words_d   = words_q;
    partial_d = partial_q;
    if (stats_clr_i) begin
      words_d   = '0;
      partial_d = '0;
    end else if (handshake) begin
      if (words_q != 16'hFFFF) begin
        words_d = words_q + 16'd1;
      end
      if ((be_q != '1) && (partial_q != 16'hFFFF)) begin
        partial_d = partial_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q   <= '0;
      partial_q <= '0;
    end else begin
      words_q   <= words_d;
      partial_q <= partial_d;
    end
  end

  assign words_emitted_o = words_q;
  assign partial_words_o = partial_q;
`endif

endmodule
